// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_pkg
// Description : Shared definitions for the memory-mapped UART: register
//               offsets, STATUS bit positions, TX/RX state encodings and a
//               helper for the receiver's half-bit delay.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Register offsets (CPU address bits [3:2])
    localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
    localparam logic [1:0] UART_REG_RXDATA  = 2'd1;
    localparam logic [1:0] UART_REG_STATUS  = 2'd2;
    localparam logic [1:0] UART_REG_DIVISOR = 2'd3;

    // STATUS bit positions
    localparam int STAT_TX_BUSY      = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_TX_FULL      = 2;
    localparam int STAT_RX_VALID     = 3;
    localparam int STAT_RX_OVERRUN   = 4;
    localparam int STAT_RX_FRAME_ERR = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Counter preload so that the start bit is re-sampled (div+1)/2 cycles
    // after the falling edge was seen (counter expires when it reaches 0).
    function automatic logic [15:0] half_period_m1(input logic [15:0] div);
        logic [15:0] half;
        half = {1'b0, div[15:1]} + {15'd0, div[0]};
        return (half == 16'd0) ? 16'd0 : half - 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous FIFO for the UART transmitter. Pointers carry one
//               extra wrap bit so full and empty are distinguishable.
//               Ports: clk, rst_n (async active-low), push/din, pop/dout
//               (first-word fall-through), full, empty, count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count   = wr_ptr_q - rd_ptr_q;
        dout    = mem_q[rd_ptr_q[AW-1:0]];
        // A full FIFO refuses a push even when it pops in the same cycle.
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart
// Description : Memory-mapped UART on the CPU word-addressed data port.
//               TX FIFO + serial transmitter, single-byte RX holding
//               register + serial receiver, programmable baud divisor.
//               Ports: clk, rst_n (async active-low), select, address[1:0],
//               memory_in[31:0], write_enable -> memory_out[31:0],
//               read_capable, write_capable (all combinational);
//               txd (serial out), rxd (serial in, asynchronous).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        select,
    input  logic [1:0]  address,
    input  logic [31:0] memory_in,
    input  logic        write_enable,
    output logic [31:0] memory_out,
    output logic        read_capable,
    output logic        write_capable,
    output logic        txd,
    input  logic        rxd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic          wr_accept;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;
    logic          unused_mem_hi;

    logic [15:0]   divisor_q, divisor_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic          rx_frame_err_q, rx_frame_err_d;
    logic [7:0]    rx_byte_q, rx_byte_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [15:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_cnt_done, tx_busy;

    rx_state_e     rx_state_q, rx_state_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic          rx_cnt_done, rx_fall;
    logic          rx_stop_sample, rx_set_frame, rx_set_ovr, rx_load;

    assign unused_mem_hi = ^memory_in[31:16];

    // ------------------------------------------------------------------
    // Bus decode (purely combinational, reads have no side effects)
    // ------------------------------------------------------------------
    always_comb begin
        read_capable  = select;
        write_capable = select && (address != UART_REG_RXDATA) &&
                        !((address == UART_REG_TXDATA) && fifo_full);
        wr_accept     = write_capable && write_enable;
        fifo_push     = wr_accept && (address == UART_REG_TXDATA);

        status_word                    = 32'd0;
        status_word[STAT_TX_BUSY]      = tx_busy;
        status_word[STAT_TX_EMPTY]     = fifo_empty;
        status_word[STAT_TX_FULL]      = fifo_full;
        status_word[STAT_RX_VALID]     = rx_valid_q;
        status_word[STAT_RX_OVERRUN]   = rx_overrun_q;
        status_word[STAT_RX_FRAME_ERR] = rx_frame_err_q;
        status_word[15:8]              = 8'(fifo_count);

        memory_out = 32'd0;
        if (select) begin
            case (address)
                UART_REG_RXDATA:  memory_out = {23'd0, rx_valid_q, rx_byte_q};
                UART_REG_STATUS:  memory_out = status_word;
                UART_REG_DIVISOR: memory_out = {16'd0, divisor_q};
                default:          memory_out = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divisor and RX flags; a flag set beats a same-cycle W1C clear
    // ------------------------------------------------------------------
    always_comb begin
        divisor_d      = divisor_q;
        rx_valid_d     = rx_valid_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;
        rx_byte_d      = rx_load ? rx_shift_q : rx_byte_q;

        if (wr_accept && (address == UART_REG_DIVISOR)) begin
            divisor_d = memory_in[15:0];
        end
        if (wr_accept && (address == UART_REG_STATUS)) begin
            if (memory_in[STAT_RX_VALID])     rx_valid_d     = 1'b0;
            if (memory_in[STAT_RX_OVERRUN])   rx_overrun_d   = 1'b0;
            if (memory_in[STAT_RX_FRAME_ERR]) rx_frame_err_d = 1'b0;
        end
        if (rx_load)      rx_valid_d     = 1'b1;
        if (rx_set_ovr)   rx_overrun_d   = 1'b1;
        if (rx_set_frame) rx_frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q      <= DEFAULT_DIVISOR;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_byte_q      <= 8'd0;
            rxd_meta_q     <= 1'b1;
            rxd_sync_q     <= 1'b1;
            rxd_prev_q     <= 1'b1;
        end else begin
            divisor_q      <= divisor_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_byte_q      <= rx_byte_d;
            rxd_meta_q     <= rxd;
            rxd_sync_q     <= rxd_meta_q;
            rxd_prev_q     <= rxd_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (memory_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Transmitter: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // The baud counter reloads from divisor_q only when a bit ends, so a
    // DIVISOR write never stretches or shortens the bit in progress.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        txd_d       = txd_q;
        tx_cnt_done = (tx_cnt_q == 16'd0);
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_state_d = TX_START;
                    tx_shift_d = fifo_dout;
                    tx_cnt_d   = divisor_q;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_done) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = divisor_q;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_done) begin
                    tx_cnt_d = divisor_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_done) begin
                    if (!fifo_empty) begin
                        tx_state_d = TX_START;
                        tx_shift_d = fifo_dout;
                        tx_cnt_d   = divisor_q;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy  = (tx_state_q != TX_IDLE);
        fifo_pop = !fifo_empty &&
                   ((tx_state_q == TX_IDLE) ||
                    ((tx_state_q == TX_STOP) && tx_cnt_done));
        txd      = txd_q;
    end

    // ------------------------------------------------------------------
    // Receiver: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_done = (rx_cnt_q == 16'd0);
        rx_fall     = rxd_prev_q && !rxd_sync_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = half_period_m1(divisor_q);
                end
            end
            RX_START: begin
                if (rx_cnt_done) begin
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;     // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = divisor_q;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_done) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};   // LSB first
                    rx_cnt_d   = divisor_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_done) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_stop_sample = (rx_state_q == RX_STOP) && rx_cnt_done;
        rx_set_frame   = rx_stop_sample && !rxd_sync_q;
        rx_set_ovr     = rx_stop_sample && rxd_sync_q && rx_valid_q;
        rx_load        = rx_stop_sample && rxd_sync_q && !rx_valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart
// Description : Self-checking bench for mmio_uart (FIFO_DEPTH=8, divisor 3).
//               Register-decode vector table, serial waveform checks, a
//               behavioural serial decoder for TX, a model of the RX holding
//               register, and reset/divisor corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_uart;

    localparam logic [1:0] A_TX = 2'd0;
    localparam logic [1:0] A_RX = 2'd1;
    localparam logic [1:0] A_ST = 2'd2;
    localparam logic [1:0] A_DV = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        select = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] memory_in = 32'd0;
    logic        write_enable = 1'b0;
    logic        rxd = 1'b1;
    logic [31:0] memory_out;
    logic        read_capable;
    logic        write_capable;
    logic        txd;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_exp_q[$];

    mmio_uart #(
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (16'd3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .select        (select),
        .address       (address),
        .memory_in     (memory_in),
        .write_enable  (write_enable),
        .memory_out    (memory_out),
        .read_capable  (read_capable),
        .write_capable (write_capable),
        .txd           (txd),
        .rxd           (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no response within the cycle budget", name);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        select = 1'b1; address = a; write_enable = 1'b0;
        #1 d = memory_out;
        select = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v, output logic wc);
        @(negedge clk);
        select = 1'b1; address = a; write_enable = 1'b1; memory_in = v;
        #1 wc = write_capable;
        @(posedge clk);
        #1 select = 1'b0; write_enable = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Called at the first sample of a start bit; compares every cycle of
    // the frame against the ideal waveform (first bit may differ in length).
    task automatic check_frame_wave(input string name, input logic [7:0] b,
                                    input int first_p, input int p);
        int bad;
        int total;
        int idx;
        bad = 0;
        total = first_p + 9 * p;
        for (int k = 0; k < total; k++) begin
            idx = (k < first_p) ? 0 : 1 + (k - first_p) / p;
            if (txd !== frame_bit(b, idx)) bad++;
            if (k != total - 1) begin
                @(posedge clk); #1;
            end
        end
        check(name, bad, 0);
    endtask

    // Behavioural serial receiver: finds each start bit, samples mid-bit,
    // and compares against the bytes queued by the writer.
    task automatic decode_frames(input int n, input int p);
        int waited;
        logic [7:0] got;
        logic [7:0] exp;
        logic stop_bit;
        for (int f = 0; f < n; f++) begin
            waited = 0;
            while (txd !== 1'b0 && waited < 40 * p) begin
                @(posedge clk); #1; waited++;
            end
            if (txd !== 1'b0) begin
                note_fail("tx_frame_timeout");
                return;
            end
            repeat (p / 2) begin @(posedge clk); #1; end
            check("tx_start_mid", txd, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (p) begin @(posedge clk); #1; end
                got[i] = txd;
            end
            repeat (p) begin @(posedge clk); #1; end
            stop_bit = txd;
            if (tx_exp_q.size() == 0) begin
                note_fail("tx_frame_unexpected");
            end else begin
                exp = tx_exp_q.pop_front();
                check("tx_frame", {23'd0, stop_bit, got}, {23'd0, 1'b1, exp});
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int p);
        @(negedge clk);
        rxd = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (p) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (p) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * p) @(negedge clk);
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic        we;
        logic [31:0] exp_out;
        logic        exp_rc;
        logic        exp_wc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        wc;
        logic [7:0]  b;
        logic [7:0]  bb;
        int          n;
        int          lows;
        logic        m_valid;
        logic        m_ovr;
        logic [7:0]  m_byte;

        vecs[0] = '{1'b0, A_DV, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, A_TX, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, A_RX, 1'b1, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, A_ST, 1'b0, 32'h2, 1'b1, 1'b1};
        vecs[4] = '{1'b1, A_DV, 1'b0, 32'h3, 1'b1, 1'b1};
        vecs[5] = '{1'b0, A_ST, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, A_RX, 1'b0, 32'h0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1);
        rst_n = 1'b1;

        // ---- Register decode table in reset state ----
        memory_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            select = vecs[i].sel; address = vecs[i].addr; write_enable = vecs[i].we;
            #1;
            check($sformatf("vec%0d_out", i), memory_out, vecs[i].exp_out);
            check($sformatf("vec%0d_rc", i), read_capable, vecs[i].exp_rc);
            check($sformatf("vec%0d_wc", i), write_capable, vecs[i].exp_wc);
        end
        @(negedge clk);
        select = 1'b0; write_enable = 1'b0;
        bus_read(A_DV, rd); check("div_after_table", rd, 32'h3);
        bus_read(A_RX, rd); check("rx_after_table", rd, 32'h0);

        // ---- Single frame 0x55 ----
        repeat (2) @(negedge clk);
        bus_write(A_TX, 32'h55, wc);
        check("tx55_wc", wc, 1);
        check("tx55_txd_edgeN", txd, 1);
        @(posedge clk); #1;
        check_frame_wave("tx55_wave", 8'h55, 4, 4);
        @(posedge clk); #1;
        bus_read(A_ST, rd); check("tx55_status_end", rd, 32'h2);

        // ---- Fill FIFO back to back, with a decoder on the line ----
        repeat (4) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bb = 8'($urandom);
                    tx_exp_q.push_back(bb);
                    bus_write(A_TX, {24'd0, bb}, wc);
                    check("fill_wc", wc, 1);
                end
                bus_read(A_ST, rd); check("fill_status_cnt7", rd, 32'h0701);
                bb = 8'($urandom);
                tx_exp_q.push_back(bb);
                bus_write(A_TX, {24'd0, bb}, wc);
                check("fill_ninth_wc", wc, 1);
                bus_write(A_TX, 32'hEE, wc);
                check("full_wc_low", wc, 0);
                bus_read(A_ST, rd); check("full_status", rd, 32'h0805);
            end
            begin
                decode_frames(9, 4);
            end
        join
        repeat (10) @(negedge clk);
        bus_read(A_ST, rd); check("drain_status", rd, 32'h2);
        check("drain_queue_empty", tx_exp_q.size(), 0);

        // ---- RX: valid, clear, overrun ----
        send_rx(8'hA3, 1'b1, 4);
        bus_read(A_RX, rd); check("rx_a3", rd, 32'h1A3);
        bus_write(A_ST, 32'h8, wc);
        bus_read(A_RX, rd); check("rx_a3_cleared", rd, 32'h0A3);
        send_rx(8'hA3, 1'b1, 4);
        send_rx(8'h5C, 1'b1, 4);
        bus_read(A_RX, rd); check("rx_overrun_keep", rd, 32'h1A3);
        bus_read(A_ST, rd); check("rx_overrun_status", rd, 32'h1A);
        bus_write(A_ST, 32'h38, wc);
        bus_read(A_ST, rd); check("rx_w1c_all", rd, 32'h2);

        // ---- RX: glitch and framing error ----
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(A_ST, rd); check("rx_glitch", rd, 32'h2);
        send_rx(8'h3C, 1'b0, 4);
        bus_read(A_ST, rd); check("rx_frame_err", rd, 32'h22);
        bus_read(A_RX, rd); check("rx_frame_err_data", rd, 32'h0A3);
        bus_write(A_ST, 32'h20, wc);

        // ---- RX random frames against holding-register model ----
        m_valid = 1'b0; m_ovr = 1'b0; m_byte = 8'hA3;
        for (int it = 0; it < 6; it++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1, 4);
            if (m_valid) m_ovr = 1'b1;
            else begin m_byte = b; m_valid = 1'b1; end
            bus_read(A_RX, rd); check("rnd_rxdata", rd, {23'd0, m_valid, m_byte});
            bus_read(A_ST, rd); check("rnd_rx_ovr", {31'd0, rd[4]}, {31'd0, m_ovr});
            if ($urandom_range(0, 1) == 1) begin
                bus_write(A_ST, 32'h18, wc);
                m_valid = 1'b0; m_ovr = 1'b0;
            end
        end

        // ---- TX random bursts with random gaps ----
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 8);
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        bb = 8'($urandom);
                        tx_exp_q.push_back(bb);
                        bus_write(A_TX, {24'd0, bb}, wc);
                        check("rnd_tx_wc", wc, 1);
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                end
                begin
                    decode_frames(n, 4);
                end
            join
        end

        // ---- DIVISOR change mid-frame ----
        repeat (10) @(negedge clk);
        bus_write(A_TX, 32'h55, wc);
        bus_write(A_DV, 32'h7, wc);
        check_frame_wave("div_change_wave", 8'h55, 4, 8);
        repeat (4) @(negedge clk);
        bus_read(A_DV, rd); check("div_readback", rd, 32'h7);

        // ---- Asynchronous reset mid-frame ----
        repeat (10) @(negedge clk);
        bus_write(A_TX, 32'h00, wc);
        bus_write(A_TX, 32'hFF, wc);
        repeat (20) @(posedge clk);
        #1 check("pre_reset_txd", txd, 0);
        #2 rst_n = 1'b0;
        #1 check("reset_async_txd", txd, 1);
        @(negedge clk); rst_n = 1'b1;
        bus_read(A_ST, rd); check("post_reset_status", rd, 32'h2);
        bus_read(A_DV, rd); check("post_reset_div", rd, 32'h3);
        lows = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check("post_reset_idle_line", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
